// File: rtl/video_pattern_gen.sv
// video_pattern_gen: self-contained fv/lv/pixel source with test patterns, start/stop control and frame counting.
module video_pattern_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int H_BLANK    = 280,
  parameter int V_BLANK    = 280
) (
  input  logic                  pix_clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] fixed_i,
  input  logic [15:0]           frames_i,
  output logic                  fv_o,
  output logic                  lv_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           frame_cnt_o
);
  localparam int XW   = $clog2(H_ACTIVE);
  localparam int YW   = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX = H_BLANK > V_BLANK ? H_BLANK : V_BLANK;
  localparam int BW   = BMAX > 1 ? $clog2(BMAX) : 1;
  typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, VBLANK} state_t;
  state_t                state_q, state_d;
  logic [BW-1:0]         b_q, b_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [15:0]           fc_q, fc_d, frames_q, frames_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fixed_q, fixed_d, data_q, data_d, pat;
  logic                  stop_q, stop_d, done_q, done_d;
  logic                  fv_q, fv_d, lv_q, lv_d, busy_q, busy_d, blk;
  always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fc_q     <= '0;
      frames_q <= '0;
      mode_q   <= '0;
      fixed_q  <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      fv_q     <= 1'b0;
      lv_q     <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fc_q     <= fc_d;
      frames_q <= frames_d;
      mode_q   <= mode_d;
      fixed_q  <= fixed_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      fv_q     <= fv_d;
      lv_q     <= lv_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    fc_d     = fc_q;
    frames_d = frames_q;
    mode_d   = mode_q;
    fixed_d  = fixed_q;
    done_d   = 1'b0;
    stop_d   = (state_q != IDLE) && (stop_q || stop_i);
    case (state_q)
      IDLE: if (start_i && !stop_i) begin
        state_d  = LEAD;
        b_d      = '0;
        y_d      = '0;
        fc_d     = '0;
        frames_d = frames_i;
        mode_d   = mode_i;
        fixed_d  = fixed_i;
      end
      LEAD: begin
        b_d = b_q + 1'b1;
        if (b_q == BW'(H_BLANK - 1)) begin
          state_d = LINE;
          x_d     = '0;
        end
      end
      LINE: if (x_q == XW'(H_ACTIVE - 1)) begin
        state_d = HBLANK;
        b_d     = '0;
      end else x_d = x_q + 1'b1;
      HBLANK: begin
        b_d = b_q + 1'b1;
        if (b_q == BW'(H_BLANK - 1)) begin
          b_d = '0;
          if (y_q == YW'(V_ACTIVE - 1)) begin
            state_d = VBLANK;
            fc_d    = fc_q == 16'hFFFF ? fc_q : fc_q + 16'd1;
          end else begin
            state_d = LINE;
            x_d     = '0;
            y_d     = y_q + 1'b1;
          end
        end
      end
      VBLANK: begin
        b_d = b_q + 1'b1;
        if (b_q == BW'(V_BLANK - 1)) begin
          b_d = '0;
          if (stop_d || (frames_q != 16'd0 && fc_q == frames_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            state_d = LEAD;
            y_d     = '0;
            mode_d  = mode_i;
            fixed_d = fixed_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the state being entered so the registers present them in that state's first cycle.
  always_comb begin
    fv_d   = state_d inside {LEAD, LINE, HBLANK};
    lv_d   = state_d == LINE;
    busy_d = state_d != IDLE;
    blk    = |((32'(x_d) ^ 32'(y_d)) & 32'd8);
    pat    = mode_d == 2'd0 ? DATA_WIDTH'(x_d) :
             mode_d == 2'd1 ? DATA_WIDTH'(y_d) :
             mode_d == 2'd2 ? {DATA_WIDTH{blk}} : fixed_d;
    data_d = lv_d ? pat : '0;
  end
  assign fv_o        = fv_q;
  assign lv_o        = lv_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = fc_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: scoreboard bench; expected pixels queued at start, checked by a free-running monitor.
module tb_video_pattern_gen;
  localparam int DW = 16, HA = 16, VA = 12, HB = 3, VB = 5;
  localparam int FV_LEN = HB + VA * (HA + HB);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = '0;
  logic [DW-1:0] fixed = '0;
  logic [15:0] frames = '0;
  logic fv_o, lv_o, busy_o, done_o;
  logic [DW-1:0] data_o;
  logic [15:0] frame_cnt_o;
  int checks = 0, failures = 0;
  logic [DW-1:0] exp_q[$];
  int fv_run = 0, low_run = 0;

  video_pattern_gen #(.DATA_WIDTH(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .pix_clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .mode_i(mode),
    .fixed_i(fixed), .frames_i(frames), .fv_o(fv_o), .lv_o(lv_o), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_pix(input int m, input logic [DW-1:0] f, input int x, input int y);
    case (m)
      0: return DW'(x);
      1: return DW'(y);
      2: return ((x / 8 + y / 8) % 2) != 0 ? {DW{1'b1}} : {DW{1'b0}};
      default: return f;
    endcase
  endfunction

  task automatic push_frames(input int m, input logic [DW-1:0] f, input int n);
    for (int fr = 0; fr < n; fr++)
      for (int y = 0; y < VA; y++)
        for (int x = 0; x < HA; x++) exp_q.push_back(model_pix(m, f, x, y));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      fv_run = 0;
      low_run = 0;
    end else begin
      if (lv_o) begin
        chk("lv_inside_fv", 32'(fv_o), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel: got %0h expected no pixel", data_o);
        end else chk("pixel", 32'(data_o), 32'(exp_q.pop_front()));
      end else chk("blank_data", 32'(data_o), 32'd0);
      if (fv_o) begin
        if (low_run > 0) chk("fv_low_len", low_run, VB);
        low_run = 0;
        fv_run++;
      end else begin
        if (fv_run > 0) chk("fv_high_len", fv_run, FV_LEN);
        fv_run = 0;
        low_run = busy_o ? low_run + 1 : 0;
      end
    end
  end

  // Mid-frame of the last frame: perturb mode/fixed, pulse start, and optionally pulse stop.
  task automatic run(input int m, input logic [DW-1:0] f, input int nfr, input int stop_at);
    int n, cyc;
    bit fired, got;
    n = nfr != 0 ? nfr : stop_at;
    cyc = 0;
    fired = 0;
    got = 0;
    @(negedge clk);
    mode = 2'(m);
    fixed = f;
    frames = 16'(nfr);
    start = 1'b1;
    push_frames(m, f, n);
    @(posedge clk);
    #1 start = 1'b0;
    chk("fv_after_start", 32'(fv_o), 32'd1);
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("cnt_cleared", 32'(frame_cnt_o), 32'd0);
    while (!got && cyc < n * (FV_LEN + VB) + 50) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      stop = 1'b0;
      if (done_o) got = 1;
      else if (!fired && lv_o && frame_cnt_o == 16'(n - 1)) begin
        fired = 1;
        mode = mode ^ 2'b11;
        fixed = ~fixed;
        start = 1'b1;
        stop = stop_at != 0;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end else begin
      chk("busy_at_done", 32'(busy_o), 32'd0);
      chk("frame_cnt_at_done", 32'(frame_cnt_o), 32'(n));
      chk("queue_drained", exp_q.size(), 32'd0);
      @(negedge clk);
      chk("done_one_pulse", 32'(done_o), 32'd0);
      chk("idle_after_done", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    #12;
    chk("rst_fv", 32'(fv_o), 32'd0);
    chk("rst_lv", 32'(lv_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_stop_busy", 32'(busy_o), 32'd0);
      chk("start_stop_fv", 32'(fv_o), 32'd0);
    end
    start = 1'b0;
    stop = 1'b0;
    run(0, 16'h0000, 2, 0);
    run(1, 16'h0000, 1, 0);
    run(2, 16'h0000, 2, 0);
    run(3, 16'h8010, 0, 3);
    for (int i = 0; i < 4; i++) begin
      int m, nf, sa;
      m = $urandom_range(0, 3);
      nf = $urandom_range(0, 2);
      sa = nf == 0 ? $urandom_range(1, 2) : 0;
      run(m, DW'($urandom), nf, sa);
    end
    @(negedge clk);
    mode = 2'd0;
    frames = 16'd0;
    start = 1'b1;
    push_frames(0, '0, 1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(lv_o && data_o == 16'd5) && cyc < 2 * FV_LEN) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_mid_line", 32'(lv_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fv", 32'(fv_o), 32'd0);
    chk("async_rst_lv", 32'(lv_o), 32'd0);
    chk("async_rst_data", 32'(data_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_cnt", 32'(frame_cnt_o), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 16'h0000, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end
endmodule
